// File: rtl/toggle_cover_collector.sv
// Toggle coverage collector: per-point saturating hit counters, a first-hit
// event stream, and a snapshot-based dump of every counter on request.
module toggle_cover_collector #(
  parameter int unsigned WIDTH       = 43,
  parameter int unsigned COVER_INDEX = 0,
  parameter int unsigned COVER_TOTAL = 38253,
  parameter int unsigned CNT_W       = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       en,
  input  logic [WIDTH-1:0]           valid,
  input  logic                       clear,
  output logic                       evt_valid,
  input  logic                       evt_ready,
  output logic [31:0]                evt_index,
  input  logic                       dump_req,
  output logic                       dump_busy,
  output logic                       dump_valid,
  input  logic                       dump_ready,
  output logic [31:0]                dump_index,
  output logic [CNT_W-1:0]           dump_count,
  output logic                       dump_last,
  output logic [$clog2(WIDTH+1)-1:0] covered_cnt
);

  localparam int unsigned CW    = $clog2(WIDTH + 1);
  localparam int unsigned PTR_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WIDTH - 1);

  // Parameter legality is checked at elaboration time.
  if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
    $error("toggle_cover_collector: WIDTH must be in 1..1024");
  end
  if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt_w
    $error("toggle_cover_collector: CNT_W must be in 1..32");
  end
  if ((64'(COVER_INDEX) + 64'(WIDTH)) > 64'(COVER_TOTAL)) begin : g_bad_range
    $error("toggle_cover_collector: COVER_INDEX+WIDTH exceeds COVER_TOTAL");
  end

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } dump_state_t;

  logic [CNT_W-1:0] hit_cnt [WIDTH];
  logic [WIDTH-1:0] seen;
  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] hit;
  logic [WIDTH-1:0] first_hit;

  logic             evt_load;
  logic             pick_found;
  logic [PTR_W-1:0] pick_idx;
  logic [WIDTH-1:0] pick_mask;

  dump_state_t      state;
  dump_state_t      state_nxt;
  logic [PTR_W-1:0] ptr;
  logic [PTR_W-1:0] ptr_nxt;
  logic             load_rec;
  logic [CNT_W-1:0] rec_cnt;

  assign hit       = en ? valid : '0;
  assign first_hit = hit & ~seen;
  assign evt_load  = !evt_valid || evt_ready;

  // Saturating hit counters and sticky seen flags; clear beats any hit.
  always_ff @(posedge clock or negedge reset) begin : p_cnt
    if (!reset) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hit_cnt[i] <= '0;
      end
      seen <= '0;
    end else if (clear) begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        hit_cnt[i] <= '0;
      end
      seen <= '0;
    end else begin
      for (int i = 0; i < int'(WIDTH); i++) begin
        if (hit[i] && (hit_cnt[i] != CNT_MAX)) begin
          hit_cnt[i] <= hit_cnt[i] + CNT_W'(1);
        end
      end
      seen <= seen | hit;
    end
  end

  // Lowest-numbered pending point wins the event register.
  always_comb begin : p_pick
    pick_found = 1'b0;
    pick_idx   = '0;
    pick_mask  = '0;
    for (int i = int'(WIDTH) - 1; i >= 0; i--) begin
      if (pending[i]) begin
        pick_found   = 1'b1;
        pick_idx     = PTR_W'(i);
        pick_mask    = '0;
        pick_mask[i] = 1'b1;
      end
    end
  end

  // Pending set and event output register.
  always_ff @(posedge clock or negedge reset) begin : p_evt
    if (!reset) begin
      pending   <= '0;
      evt_valid <= 1'b0;
      evt_index <= '0;
    end else if (clear) begin
      pending   <= '0;
      evt_valid <= 1'b0;
    end else begin
      if (evt_load) begin
        pending   <= (pending & ~pick_mask) | first_hit;
        evt_valid <= pick_found;
        if (pick_found) begin
          evt_index <= 32'(COVER_INDEX) + 32'(pick_idx);
        end
      end else begin
        pending <= pending | first_hit;
      end
    end
  end

  always_comb begin : p_popcount
    covered_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      covered_cnt = covered_cnt + CW'(seen[i]);
    end
  end

  // Dump FSM next-state; clear overrides every transition.
  always_comb begin : p_dump_nxt
    state_nxt = state;
    ptr_nxt   = ptr;
    load_rec  = 1'b0;
    case (state)
      S_IDLE: begin
        if (dump_req) begin
          state_nxt = S_SEND;
          ptr_nxt   = '0;
          load_rec  = 1'b1;
        end
      end
      S_SEND: begin
        if (dump_ready) begin
          if (ptr == LAST_PTR) begin
            state_nxt = S_IDLE;
            ptr_nxt   = '0;
          end else begin
            ptr_nxt  = ptr + PTR_W'(1);
            load_rec = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = S_IDLE;
        ptr_nxt   = '0;
      end
    endcase
    if (clear) begin
      state_nxt = S_IDLE;
      ptr_nxt   = '0;
      load_rec  = 1'b0;
    end
  end

  // Snapshot source: the counter value at the edge the record is loaded.
  always_comb begin : p_rec_mux
    rec_cnt = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (PTR_W'(i) == ptr_nxt) begin
        rec_cnt = hit_cnt[i];
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin : p_dump_reg
    if (!reset) begin
      state      <= S_IDLE;
      ptr        <= '0;
      dump_index <= '0;
      dump_count <= '0;
      dump_last  <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      if (load_rec) begin
        dump_index <= 32'(COVER_INDEX) + 32'(ptr_nxt);
        dump_count <= rec_cnt;
        dump_last  <= (ptr_nxt == LAST_PTR);
      end else if (state_nxt == S_IDLE) begin
        dump_last <= 1'b0;
      end
    end
  end

  assign dump_busy  = (state == S_SEND);
  assign dump_valid = (state == S_SEND);

endmodule

// File: tb/tb_toggle_cover_collector.sv
// Directed bench for toggle_cover_collector (WIDTH=43, COVER_INDEX=100, CNT_W=8).
module tb_toggle_cover_collector;

  localparam int unsigned W  = 43;
  localparam int unsigned CI = 100;
  localparam int unsigned CW = $clog2(W + 1);

  logic          clock;
  logic          reset;
  logic          en;
  logic [W-1:0]  valid;
  logic          clear;
  logic          evt_valid;
  logic          evt_ready;
  logic [31:0]   evt_index;
  logic          dump_req;
  logic          dump_busy;
  logic          dump_valid;
  logic          dump_ready;
  logic [31:0]   dump_index;
  logic [7:0]    dump_count;
  logic          dump_last;
  logic [CW-1:0] covered_cnt;

  int unsigned vecs;
  int unsigned errs;

  toggle_cover_collector #(
    .WIDTH(W), .COVER_INDEX(CI), .COVER_TOTAL(38253), .CNT_W(8)
  ) dut (
    .clock(clock), .reset(reset), .en(en), .valid(valid), .clear(clear),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_index(evt_index),
    .dump_req(dump_req), .dump_busy(dump_busy), .dump_valid(dump_valid),
    .dump_ready(dump_ready), .dump_index(dump_index), .dump_count(dump_count),
    .dump_last(dump_last), .covered_cnt(covered_cnt)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; valid = '1; clear = 1'b1; dump_req = 1'b1;
    evt_ready = 1'b0; dump_ready = 1'b0;
    repeat (3) step();
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL rst_evt_valid: got %0b expected 0", evt_valid); end
    vecs++; if (evt_index !== 32'd0) begin errs++; $display("FAIL rst_evt_index: got %0d expected 0", evt_index); end
    vecs++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_last !== 1'b0) begin errs++; $display("FAIL rst_dump_flags: got %0b%0b%0b expected 000", dump_busy, dump_valid, dump_last); end
    vecs++; if (dump_index !== 32'd0 || dump_count !== 8'd0) begin errs++; $display("FAIL rst_dump_data: got %0d/%0d expected 0/0", dump_index, dump_count); end
    vecs++; if (covered_cnt !== CW'(0)) begin errs++; $display("FAIL rst_covered: got %0d expected 0", covered_cnt); end
    valid = '0; clear = 1'b0; dump_req = 1'b0; en = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
    vecs++; if (covered_cnt !== CW'(0) || evt_valid !== 1'b0 || dump_busy !== 1'b0) begin errs++; $display("FAIL rst_release: got cov=%0d ev=%0b busy=%0b expected 0/0/0", covered_cnt, evt_valid, dump_busy); end
  endtask

  task automatic test_single_event();
    en = 1'b1; evt_ready = 1'b1;
    valid = '0; valid[5] = 1'b1;
    step();
    valid = '0;
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL single_lat1: got %0b expected 0", evt_valid); end
    vecs++; if (covered_cnt !== CW'(1)) begin errs++; $display("FAIL single_covered: got %0d expected 1", covered_cnt); end
    step();
    vecs++; if (evt_valid !== 1'b1) begin errs++; $display("FAIL single_lat2: got %0b expected 1", evt_valid); end
    vecs++; if (evt_index !== 32'd105) begin errs++; $display("FAIL single_index: got %0d expected 105", evt_index); end
    step();
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL single_one_cycle: got %0b expected 0", evt_valid); end
  endtask

  task automatic test_backpressure();
    evt_ready = 1'b0;
    valid = '0; valid[3] = 1'b1; valid[7] = 1'b1; valid[42] = 1'b1;
    step();
    valid = '0;
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL bp_lat1: got %0b expected 0", evt_valid); end
    step();
    vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd103) begin errs++; $display("FAIL bp_first: got v=%0b idx=%0d expected v=1 idx=103", evt_valid, evt_index); end
    for (int k = 0; k < 5; k++) begin
      step();
      vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd103) begin errs++; $display("FAIL bp_hold%0d: got v=%0b idx=%0d expected v=1 idx=103", k, evt_valid, evt_index); end
    end
    evt_ready = 1'b1;
    step();
    vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd107) begin errs++; $display("FAIL bp_second: got v=%0b idx=%0d expected v=1 idx=107", evt_valid, evt_index); end
    step();
    vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd142) begin errs++; $display("FAIL bp_third: got v=%0b idx=%0d expected v=1 idx=142", evt_valid, evt_index); end
    step();
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL bp_drained: got %0b expected 0", evt_valid); end
    valid = '0; valid[7] = 1'b1;
    step();
    valid = '0;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL bp_rehit%0d: got %0b expected 0", k, evt_valid); end
    end
    vecs++; if (covered_cnt !== CW'(4)) begin errs++; $display("FAIL bp_covered: got %0d expected 4", covered_cnt); end
  endtask

  task automatic test_saturate();
    clear = 1'b1;
    step();
    clear = 1'b0;
    vecs++; if (covered_cnt !== CW'(0)) begin errs++; $display("FAIL sat_cleared: got %0d expected 0", covered_cnt); end
    evt_ready = 1'b1;
    for (int c = 0; c < 300; c++) begin
      valid = '0;
      valid[0] = 1'b1;
      if (c < 4) valid[1] = 1'b1;
      step();
    end
    valid = '0;
    step();
    vecs++; if (covered_cnt !== CW'(2)) begin errs++; $display("FAIL sat_covered: got %0d expected 2", covered_cnt); end
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL sat_evt_idle: got %0b expected 0", evt_valid); end
  endtask

  task automatic test_dump();
    int          exp_ptr;
    int          cyc;
    logic [7:0]  exp_cnt;
    logic        acc;
    dump_ready = 1'b0;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    exp_ptr = 0;
    cyc = 0;
    while (exp_ptr < int'(W) && cyc < 400) begin
      exp_cnt = (exp_ptr == 0) ? 8'd255 : ((exp_ptr == 1) ? 8'd4 : 8'd0);
      vecs++; if (dump_valid !== 1'b1 || dump_busy !== 1'b1) begin errs++; $display("FAIL dump_active%0d: got v=%0b busy=%0b expected 1/1", exp_ptr, dump_valid, dump_busy); end
      vecs++; if (dump_index !== 32'(CI + exp_ptr)) begin errs++; $display("FAIL dump_index%0d: got %0d expected %0d", exp_ptr, dump_index, CI + exp_ptr); end
      vecs++; if (dump_count !== exp_cnt) begin errs++; $display("FAIL dump_count%0d: got %0d expected %0d", exp_ptr, dump_count, exp_cnt); end
      vecs++; if (dump_last !== (exp_ptr == int'(W) - 1)) begin errs++; $display("FAIL dump_last%0d: got %0b expected %0b", exp_ptr, dump_last, exp_ptr == int'(W) - 1); end
      acc = (cyc % 2 == 0);
      dump_ready = acc;
      dump_req = (exp_ptr == 20);
      step();
      cyc++;
      if (acc) exp_ptr++;
    end
    dump_ready = 1'b0;
    dump_req = 1'b0;
    vecs++; if (exp_ptr !== int'(W)) begin errs++; $display("FAIL dump_records: got %0d expected %0d", exp_ptr, W); end
    vecs++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_last !== 1'b0) begin errs++; $display("FAIL dump_done: got busy=%0b v=%0b last=%0b expected 0/0/0", dump_busy, dump_valid, dump_last); end
    step();
    vecs++; if (dump_busy !== 1'b0) begin errs++; $display("FAIL dump_no_restart: got %0b expected 0", dump_busy); end
  endtask

  task automatic test_clear();
    int exp_ptr;
    int cyc;
    evt_ready = 1'b0;
    valid = '0; valid[10] = 1'b1; valid[11] = 1'b1; valid[12] = 1'b1;
    step();
    valid = '0;
    step();
    vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd110) begin errs++; $display("FAIL clr_pre_evt: got v=%0b idx=%0d expected v=1 idx=110", evt_valid, evt_index); end
    dump_ready = 1'b0;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    step();
    vecs++; if (dump_busy !== 1'b1) begin errs++; $display("FAIL clr_pre_busy: got %0b expected 1", dump_busy); end
    clear = 1'b1; dump_req = 1'b1; evt_ready = 1'b1; dump_ready = 1'b1;
    valid = '0; valid[20] = 1'b1;
    step();
    clear = 1'b0; dump_req = 1'b0; valid = '0; dump_ready = 1'b0;
    vecs++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0) begin errs++; $display("FAIL clr_busy: got busy=%0b v=%0b expected 0/0", dump_busy, dump_valid); end
    vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL clr_evt: got %0b expected 0", evt_valid); end
    vecs++; if (covered_cnt !== CW'(0)) begin errs++; $display("FAIL clr_covered: got %0d expected 0", covered_cnt); end
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (evt_valid !== 1'b0) begin errs++; $display("FAIL clr_no_stale%0d: got %0b expected 0", k, evt_valid); end
    end
    dump_ready = 1'b1;
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    exp_ptr = 0;
    cyc = 0;
    while (exp_ptr < int'(W) && cyc < 200) begin
      vecs++; if (dump_valid !== 1'b1 || dump_index !== 32'(CI + exp_ptr) || dump_count !== 8'd0) begin errs++; $display("FAIL clr_dump%0d: got v=%0b idx=%0d cnt=%0d expected v=1 idx=%0d cnt=0", exp_ptr, dump_valid, dump_index, dump_count, CI + exp_ptr); end
      step();
      cyc++;
      exp_ptr++;
    end
    dump_ready = 1'b0;
    vecs++; if (dump_busy !== 1'b0) begin errs++; $display("FAIL clr_dump_end: got %0b expected 0", dump_busy); end
  endtask

  task automatic test_async_reset();
    evt_ready = 1'b0;
    valid = '0; valid[30] = 1'b1; valid[31] = 1'b1;
    step();
    valid = '0;
    step();
    vecs++; if (evt_valid !== 1'b1 || evt_index !== 32'd130) begin errs++; $display("FAIL ar_pre_evt: got v=%0b idx=%0d expected v=1 idx=130", evt_valid, evt_index); end
    dump_req = 1'b1;
    step();
    dump_req = 1'b0;
    vecs++; if (dump_busy !== 1'b1 || dump_index !== 32'd100) begin errs++; $display("FAIL ar_pre_dump: got busy=%0b idx=%0d expected 1/100", dump_busy, dump_index); end
    #3;
    reset = 1'b0;
    #1;
    vecs++; if (evt_valid !== 1'b0 || evt_index !== 32'd0) begin errs++; $display("FAIL ar_evt: got v=%0b idx=%0d expected 0/0", evt_valid, evt_index); end
    vecs++; if (dump_busy !== 1'b0 || dump_valid !== 1'b0 || dump_last !== 1'b0) begin errs++; $display("FAIL ar_dump_flags: got %0b%0b%0b expected 000", dump_busy, dump_valid, dump_last); end
    vecs++; if (dump_index !== 32'd0 || dump_count !== 8'd0) begin errs++; $display("FAIL ar_dump_data: got %0d/%0d expected 0/0", dump_index, dump_count); end
    vecs++; if (covered_cnt !== CW'(0)) begin errs++; $display("FAIL ar_covered: got %0d expected 0", covered_cnt); end
    @(negedge clock);
    reset = 1'b1;
    evt_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      vecs++; if (evt_valid !== 1'b0 || dump_busy !== 1'b0 || covered_cnt !== CW'(0)) begin errs++; $display("FAIL ar_after%0d: got ev=%0b busy=%0b cov=%0d expected 0/0/0", k, evt_valid, dump_busy, covered_cnt); end
    end
  endtask

  initial begin
    clock = 1'b0;
    vecs = 0;
    errs = 0;
    test_reset();
    test_single_event();
    test_backpressure();
    test_saturate();
    test_dump();
    test_clear();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
